// File: rtl/rx_fifo_wr_arb_if.sv
// rtl/rx_fifo_wr_arb_if.sv - requester/FIFO-write bundle for rx_fifo_wr_arb
// Purpose: groups the lane requests and the FIFO write port into one bundle.
// Ports:
//   req/req_data/req_last : lane word-valid, packed words (lane i at [i*DSIZE +: DSIZE]), end-of-burst
//   ack                   : one-hot word-accepted strobe back to the lanes
//   wfull                 : registered FIFO full flag
//   winc/wdata            : FIFO write enable and data
//   gnt_id/busy/wcount    : current/last grantee, grant held, total words written (mod 2^16)
// Modports: slave = arbiter side, master = lanes + FIFO side.
interface rx_fifo_wr_arb_if #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 10
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_last;
    logic [NREQ-1:0]       ack;
    logic                  wfull;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic [IW-1:0]         gnt_id;
    logic                  busy;
    logic [15:0]           wcount;

    modport slave (
        input  req, req_data, req_last, wfull,
        output ack, winc, wdata, gnt_id, busy, wcount
    );

    modport master (
        output req, req_data, req_last, wfull,
        input  ack, winc, wdata, gnt_id, busy, wcount
    );
endinterface

// File: rtl/rx_fifo_wr_arb.sv
// rtl/rx_fifo_wr_arb.sv - burst-atomic round-robin write-port arbiter for the PCS RX async FIFO
// Purpose: NREQ lanes share the single FIFO write port. A grant is held until the
// grantee's last word or MAXBURST words, writes are throttled by wfull, and one
// IDLE arbitration cycle separates consecutive grants.
// Ports:
//   wclk : write-domain clock
//   wrst : synchronous active-high reset
//   bus  : rx_fifo_wr_arb_if slave (req/req_data/req_last/wfull in;
//          ack/winc/wdata/gnt_id/busy/wcount out)
module rx_fifo_wr_arb #(
    parameter int NREQ     = 4,
    parameter int DSIZE    = 10,
    parameter int MAXBURST = 16
) (
    input  logic            wclk,
    input  logic            wrst,
    rx_fifo_wr_arb_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = $clog2(MAXBURST + 1);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [IW-1:0] gnt_q;
    logic [IW-1:0] gnt_d;
    logic [BW-1:0] bcnt_q;
    logic [15:0]   wcount_q;

    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic          winc_c;
    logic          burst_end;
    logic          rel_c;

    // Rotating priority: the lane after the last grantee is looked at first,
    // so a lane that was just served (or force-released) goes to the back.
    always_comb begin
        int cand;
        pick_found = 1'b0;
        pick_idx   = gnt_q;
        cand       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(gnt_q) + k) % NREQ;
            if (!pick_found && bus.req[cand[IW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IW-1:0];
            end
        end
    end

    // wrst gates the write in the reset cycle itself so a mid-burst reset
    // cannot leak one more word into the FIFO.
    assign winc_c    = (state_q == LOCK) && bus.req[gnt_q] && !bus.wfull && !wrst;
    assign burst_end = (bcnt_q == BW'(MAXBURST - 1));
    assign rel_c     = winc_c && (bus.req_last[gnt_q] || burst_end);

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q  <= IDLE;
            gnt_q    <= IW'(NREQ - 1);
            bcnt_q   <= '0;
            wcount_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            if (state_q == IDLE && pick_found) begin
                bcnt_q <= '0;
            end else if (winc_c) begin
                bcnt_q <= bcnt_q + 1'b1;
            end
            wcount_q <= wcount_q + {15'd0, winc_c};
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = LOCK;
                    gnt_d   = pick_idx;
                end
            end
            LOCK: begin
                if (rel_c) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // wdata always shows the grantee's slice; it only matters while winc=1.
    always_comb begin
        bus.winc   = winc_c;
        bus.wdata  = bus.req_data[gnt_q*DSIZE +: DSIZE];
        bus.ack    = '0;
        if (winc_c) begin
            bus.ack[gnt_q] = 1'b1;
        end
        bus.gnt_id = gnt_q;
        bus.busy   = (state_q == LOCK);
        bus.wcount = wcount_q;
    end
endmodule

// File: tb/tb_rx_fifo_wr_arb.sv
// tb/tb_rx_fifo_wr_arb.sv - self-checking bench for rx_fifo_wr_arb
module tb_rx_fifo_wr_arb;
    localparam int NREQ     = 4;
    localparam int DSIZE    = 10;
    localparam int MAXBURST = 16;
    localparam int IW       = 2;

    logic wclk = 1'b0;
    logic wrst = 1'b1;
    always #5 wclk = ~wclk;

    rx_fifo_wr_arb_if #(.NREQ(NREQ), .DSIZE(DSIZE)) bus ();

    rx_fifo_wr_arb #(.NREQ(NREQ), .DSIZE(DSIZE), .MAXBURST(MAXBURST)) dut (
        .wclk (wclk),
        .wrst (wrst),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (compare process) ----------------
    // owner = -1 when no grant is held; last = most recent grantee.
    int m_owner = -1;
    int m_last  = NREQ - 1;
    int m_words = 0;
    int m_total = 0;
    bit chk_en  = 1'b1;

    always @(negedge wclk) begin : compare
        bit               e_winc;
        logic [NREQ-1:0]  e_ack;
        int               idx;
        if (chk_en) begin
            e_winc = (m_owner >= 0) && bus.req[m_owner] && !bus.wfull && !wrst;
            e_ack  = e_winc ? NREQ'(1 << m_owner) : '0;
            check("winc", bus.winc, e_winc);
            check("ack", bus.ack, e_ack);
            check("busy", bus.busy, m_owner >= 0);
            check("gnt_id", bus.gnt_id, m_last);
            check("wcount", bus.wcount, m_total % 65536);
            if (e_winc)
                check("wdata", bus.wdata, bus.req_data[m_owner*DSIZE +: DSIZE]);
            if (wrst) begin
                m_owner = -1;
                m_last  = NREQ - 1;
                m_words = 0;
                m_total = 0;
            end else if (m_owner < 0) begin
                for (int k = 1; k <= NREQ; k++) begin
                    idx = (m_last + k) % NREQ;
                    if (m_owner < 0 && bus.req[idx]) begin
                        m_owner = idx;
                        m_last  = idx;
                        m_words = 0;
                    end
                end
            end else if (e_winc) begin
                m_total++;
                m_words++;
                if (bus.req_last[m_owner] || m_words == MAXBURST)
                    m_owner = -1;
            end
        end
    end

    // ---------------- lane agents ----------------
    int               ag_len[NREQ];
    int               ag_left[NREQ];
    int               ag_bursts[NREQ];
    logic [DSIZE-1:0] ag_data[NREQ];
    bit               ag_hold[NREQ];
    bit               ag_rand_len = 1'b0;
    bit               c_wrst  = 1'b1;
    bit               c_wfull = 1'b0;

    logic [NREQ-1:0]  s_ack    = '0;
    logic             s_winc   = 1'b0;
    logic             s_busy   = 1'b0;
    logic             prev_busy = 1'b0;
    logic [DSIZE-1:0] s_wdata  = '0;
    logic [IW-1:0]    s_gnt    = '0;
    logic [15:0]      s_wcount = '0;
    int               n_writes  = 0;
    int               full_viol = 0;
    int               grant_log[$];

    function automatic int new_len(input int i);
        if (ag_rand_len)
            return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(17, 40));
        return (ag_len[i] > 0) ? ag_len[i] : -1;
    endfunction

    task automatic start(input int i, input int len, input int nbursts);
        ag_len[i]    = len;
        ag_bursts[i] = nbursts;
        ag_left[i]   = new_len(i);
        ag_hold[i]   = 1'b0;
        ag_data[i]   = DSIZE'(i * 128);
    endtask

    task automatic advance();
        for (int i = 0; i < NREQ; i++) begin
            if (s_ack[i]) begin
                ag_data[i] = ag_data[i] + 1'b1;
                if (ag_left[i] > 0) begin
                    ag_left[i]--;
                    if (ag_left[i] == 0) begin
                        if (ag_bursts[i] > 0) ag_bursts[i]--;
                        if (ag_bursts[i] != 0) ag_left[i] = new_len(i);
                    end
                end
            end
        end
    endtask

    task automatic drive();
        wrst      = c_wrst;
        bus.wfull = c_wfull;
        for (int i = 0; i < NREQ; i++) begin
            bus.req[i]                    = (ag_bursts[i] != 0) && !ag_hold[i];
            bus.req_last[i]               = bus.req[i] && (ag_left[i] == 1);
            bus.req_data[i*DSIZE +: DSIZE] = ag_data[i];
        end
    endtask

    task automatic step();
        @(posedge wclk);
        #1;
        advance();
        drive();
        @(negedge wclk);
        s_ack    = bus.ack;
        s_winc   = bus.winc;
        s_wdata  = bus.wdata;
        s_gnt    = bus.gnt_id;
        s_busy   = bus.busy;
        s_wcount = bus.wcount;
        if (s_winc) n_writes++;
        if (s_winc && bus.wfull) full_viol++;
        if (s_busy && !prev_busy) grant_log.push_back(int'(s_gnt));
        prev_busy = s_busy;
    endtask

    task automatic reset_dut();
        ag_rand_len = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            ag_bursts[i] = 0;
            ag_hold[i]   = 1'b0;
        end
        c_wfull = 1'b0;
        c_wrst  = 1'b1;
        step();
        step();
        c_wrst = 1'b0;
        grant_log.delete();
        n_writes  = 0;
        prev_busy = 1'b0;
    endtask

    initial begin : stim
        logic [7:0] trace;
        int exp_g[4];
        int turns, cur_w, cur_gnt, gap, turn_w, cnt1, cnt3, early, guard;
        bit in_turn;

        for (int i = 0; i < NREQ; i++) begin
            ag_bursts[i] = 0;
            ag_left[i]   = 0;
            ag_len[i]    = 0;
            ag_data[i]   = '0;
            ag_hold[i]   = 1'b0;
        end
        bus.req      = '0;
        bus.req_last = '0;
        bus.req_data = '0;
        bus.wfull    = 1'b0;

        // reset values
        reset_dut();
        check("rst_busy", s_busy, 0);
        check("rst_gnt_id", s_gnt, NREQ - 1);
        check("rst_wcount", s_wcount, 0);
        check("rst_winc", s_winc, 0);
        check("rst_ack", s_ack, 0);

        // lanes 0 and 2, 3-word bursts
        start(0, 3, 2);
        start(2, 3, 2);
        trace = '0;
        for (int c = 0; c < 8; c++) begin
            step();
            trace = {trace[6:0], s_winc};
        end
        check("t1_winc_pattern", trace, 8'b0111_0111);
        step();
        check("t1_wcount_after_2", s_wcount, 6);
        for (int g = 0; g < 50 && !(grant_log.size() >= 4 && !s_busy); g++) step();
        exp_g = '{0, 2, 0, 2};
        check("t1_grant_count", grant_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            check("t1_grant_order", grant_log[i], exp_g[i]);
        check("t1_wcount_final", s_wcount, 12);

        // all lanes, never last: forced release every MAXBURST words
        reset_dut();
        for (int i = 0; i < NREQ; i++) start(i, 0, -1);
        turns = 0; cur_w = 0; cur_gnt = 0; gap = 0; in_turn = 1'b0;
        for (int g = 0; g < 120 && turns < 5; g++) begin
            step();
            if (s_busy && !in_turn) begin
                if (turns > 0) check("t2_gap", gap, 1);
                in_turn = 1'b1;
                cur_w   = int'(s_winc);
                cur_gnt = int'(s_gnt);
            end else if (s_busy) begin
                cur_w += int'(s_winc);
            end else if (in_turn) begin
                check("t2_turn_gnt", cur_gnt, turns % NREQ);
                check("t2_turn_writes", cur_w, MAXBURST);
                turns++;
                in_turn = 1'b0;
                gap     = 1;
            end else begin
                gap++;
            end
        end
        check("t2_turns_seen", turns, 5);

        // wfull stall mid-burst on grantee 1
        reset_dut();
        start(1, 0, -1);
        for (int c = 0; c < 4; c++) step();
        check("t3_pre_gnt", s_gnt, 1);
        check("t3_pre_writes", n_writes, 3);
        c_wfull = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check("t3_stall_winc", s_winc, 0);
            check("t3_stall_ack", s_ack, 0);
            check("t3_stall_busy", s_busy, 1);
        end
        c_wfull = 1'b0;
        step();
        check("t3_resume_winc", s_winc, 1);
        check("t3_resume_wdata", s_wdata, 128 + 3);
        turn_w = 4;
        for (guard = 0; guard < 40 && s_busy; guard++) begin
            step();
            turn_w += int'(s_winc);
        end
        check("t3_burst_writes", turn_w, MAXBURST);

        // grantee drops req mid-burst while lane 3 waits
        reset_dut();
        start(1, 8, 1);
        start(3, 4, 1);
        cnt1 = 0; cnt3 = 0; early = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            cnt1 += int'(s_ack[1]);
        end
        ag_hold[1] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check("t4_hold_busy", s_busy, 1);
            check("t4_hold_gnt", s_gnt, 1);
            check("t4_hold_ack", s_ack, 0);
        end
        ag_hold[1] = 1'b0;
        for (guard = 0; guard < 40 && cnt3 < 4; guard++) begin
            step();
            if (s_ack[3] && cnt1 < 8) early++;
            cnt1 += int'(s_ack[1]);
            cnt3 += int'(s_ack[3]);
        end
        check("t4_early_ack3", early, 0);
        check("t4_cnt1", cnt1, 8);
        check("t4_cnt3", cnt3, 4);

        // reset pulse during a LOCK burst
        reset_dut();
        start(2, 0, -1);
        for (int c = 0; c < 4; c++) step();
        check("t5_pre_busy", s_busy, 1);
        c_wrst = 1'b1;
        start(1, 0, -1);
        step();
        check("t5_rst_winc", s_winc, 0);
        check("t5_rst_ack", s_ack, 0);
        c_wrst = 1'b0;
        step();
        check("t5_post_busy", s_busy, 0);
        check("t5_post_gnt", s_gnt, NREQ - 1);
        check("t5_post_wcount", s_wcount, 0);
        step();
        check("t5_next_busy", s_busy, 1);
        check("t5_next_gnt", s_gnt, 1);

        // randomized traffic until wcount wraps
        reset_dut();
        ag_rand_len = 1'b1;
        for (int i = 0; i < NREQ; i++) start(i, 0, -1);
        full_viol = 0;
        for (guard = 0; guard < 90000 && n_writes < 65537; guard++) begin
            c_wfull = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < NREQ; i++)
                ag_hold[i] = ($urandom_range(0, 199) == 0);
            step();
        end
        for (int i = 0; i < NREQ; i++) begin
            ag_bursts[i] = 0;
            ag_hold[i]   = 1'b0;
        end
        c_wfull = 1'b0;
        step();
        check("t6_writes", n_writes, 65537);
        check("t6_wcount_wrap", s_wcount, 1);
        check("t6_winc_while_full", full_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
